// File: rtl/key_pkg.sv
// Shared definitions for key-gesture logic: FSM state encoding and key polarity.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } state_t;

    localparam logic KEY_PRESSED = 1'b0;

endpackage

// File: rtl/key_click_classifier_edge.sv
// Press/release edge detector for a debounced active-low key level.
module key_edge_detect
    import key_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic key_state,
    output logic fall,
    output logic rise
);

    logic key_d;

    // Resetting to "released" turns a key already held at reset release into a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_d <= ~KEY_PRESSED;
        end else begin
            key_d <= key_state;
        end
    end

    assign fall = (key_d != KEY_PRESSED) && (key_state == KEY_PRESSED);
    assign rise = (key_d == KEY_PRESSED) && (key_state != KEY_PRESSED);

endmodule

// File: rtl/key_click_classifier.sv
// Classifies key gestures into single click, double click or long press pulses
// using one shared cycle counter.
module key_click_classifier
    import key_pkg::*;
#(
    parameter int LONG_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 15_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_state,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic busy
);

    localparam int MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    logic fall;
    logic rise;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             single_next;
    logic             double_next;
    logic             long_next;

    key_edge_detect u_edge (
        .clk       (clk),
        .rst       (rst),
        .key_state (key_state),
        .fall      (fall),
        .rise      (rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            single_click <= single_next;
            double_click <= double_next;
            long_press   <= long_next;
        end
    end

    // Key edges are tested before terminal counts so a coincident edge always wins.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        single_next = 1'b0;
        double_next = 1'b0;
        long_next   = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_next = PRESS1;
                    cnt_next   = '0;
                end
            end
            PRESS1: begin
                if (rise) begin
                    state_next = WAIT2;
                    cnt_next   = '0;
                end else if (cnt == LONG_LAST) begin
                    state_next = LONG_HOLD;
                    cnt_next   = '0;
                    long_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            LONG_HOLD: begin
                if (rise) begin
                    state_next = IDLE;
                end
            end
            WAIT2: begin
                if (fall) begin
                    state_next = PRESS2;
                    cnt_next   = '0;
                end else if (cnt == GAP_LAST) begin
                    state_next  = IDLE;
                    cnt_next    = '0;
                    single_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PRESS2: begin
                if (rise) begin
                    state_next  = IDLE;
                    double_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/key_click_classifier.md
Name: key_click_classifier

Overview:
- Downstream consumer of the key debouncer. Takes its clean, active-low key_state level and classifies each user gesture as a single click, a double click or a long press.
- Emits one-cycle event pulses for application logic such as LED, mode or counter control.
- Pure timing FSM with one shared cycle counter.

Parameters:
LONG_CYCLES, 50_000_000, clocks the key must stay pressed to count as a long press (1 s at 50 MHz)
GAP_CYCLES, 15_000_000, maximum released gap between two clicks for a double click (300 ms)
CNT_W, $clog2(max(LONG_CYCLES,GAP_CYCLES))+1, counter width (derived, do not override)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
key_state  input  1  debounced key level from the debouncer; 0 = pressed, 1 = released; synchronous to clk
single_click  output  1  one-cycle pulse: one completed short press
double_click  output  1  one-cycle pulse: two short presses within the gap
long_press  output  1  one-cycle pulse: key held for LONG_CYCLES
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (rst). All outputs 0; state IDLE; cnt 0; key_d (previous key sample) 1.
- Edge detect:
  - fall = key_d & ~key_state.
  - rise = ~key_d & key_state.
  - key_d <= key_state every cycle.
  - A key already held when rst deasserts is detected as a fall on the first cycle.
- States:
  - IDLE: on fall go to PRESS1 with cnt=0.
  - PRESS1: if rise, go to WAIT2 with cnt=0. Else if cnt==LONG_CYCLES-1, pulse long_press and go to LONG_HOLD. Else cnt++.
  - LONG_HOLD: on rise go to IDLE. Never emits a click.
  - WAIT2: if fall, go to PRESS2. Else if cnt==GAP_CYCLES-1, pulse single_click and go to IDLE. Else cnt++.
  - PRESS2: on rise pulse double_click and go to IDLE. There is no long-press detection in PRESS2; an arbitrarily long second press still yields double_click on release.
- Simultaneous events:
  - In PRESS1 a rise on the terminal-count cycle wins: go to WAIT2, no long_press.
  - In WAIT2 a fall on the terminal-count cycle wins: go to PRESS2, no single_click.
- Output timing:
  - All pulses are registered, high for exactly 1 clk in the cycle after the deciding sample.
  - At most one pulse per gesture; pulses are mutually exclusive.
- busy: registered, equals (state != IDLE). It is 0 again in the same cycle as the final pulse.
- Reset mid-gesture: abort silently, no pulse, busy 0. The next gesture requires a new fall; with the key still held, the key_d reset value produces that fall.
- Counter saturation is impossible: every state exits at its terminal count.

Decomposition:
- Package key_pkg:
  - state encoding localparams (IDLE, PRESS1, WAIT2, PRESS2, LONG_HOLD; 3 bits)
  - KEY_PRESSED=1'b0 constant
- Optional sub-module key_edge_detect (key_d register plus fall/rise outputs, rst value 1). It is reusable by other key consumers.
- The FSM and counter stay in the top module.

Test Plan (LONG_CYCLES=100, GAP_CYCLES=40, 20 ns clock):
- Reset: hold rst 5 cycles with key_state=1 -> all outputs 0, busy 0. Release rst -> no pulse for 200 cycles.
- Single click: press 10 cycles, release (rise sampled at cycle R) -> single_click high only at cycle R+41, busy falls at R+41, no other pulse.
- Double click: press 10, release 20, press 10, release (second rise at cycle S) -> double_click high only at S+1, no single_click.
- Long press: hold 150 cycles (fall sampled at cycle F) -> long_press high only at F+101. Release -> no click pulse, busy 0 one cycle after the rise.
- Gap boundary, case A: release gap with the fall on WAIT2 terminal cycle (40th WAIT2 cycle) -> double_click on the second release.
- Gap boundary, case B: a gap one cycle longer -> single_click, then the second press starts a fresh gesture.
- Abort: assert rst during WAIT2 (cycle 20 of gap) -> no pulse, busy 0 immediately. Press-release after reset -> normal single_click 41 cycles after the rise.
